// File: rtl/ctr_scan_host.sv
// Scan-port host for the 16-bit control register: shifts in a command frame,
// issues a one-cycle write or a handshaken read, and shifts read data back out.
module ctr_scan_host #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_en,
    input  logic          scan_in,
    input  logic          scan_update,
    output logic          scan_out,
    output logic          ctr_wen,
    output logic          ctr_ren,
    output logic [DW-1:0] ctr_wdata,
    input  logic [DW-1:0] ctr_rdata,
    input  logic          ctr_ready,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state, state_nxt;
    logic [DW:0]   shreg, shreg_nxt;
    logic          wen_nxt, ren_nxt, err_nxt;
    logic [DW-1:0] wdata_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            ctr_wen   <= 1'b0;
            ctr_ren   <= 1'b0;
            ctr_wdata <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            ctr_wen   <= wen_nxt;
            ctr_ren   <= ren_nxt;
            ctr_wdata <= wdata_nxt;
            err       <= err_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        wen_nxt   = ctr_wen;
        ren_nxt   = ctr_ren;
        wdata_nxt = ctr_wdata;
        err_nxt   = err;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                // Update takes priority over shifting so the command is the pre-shift frame.
                if (scan_update) begin
                    err_nxt = 1'b0;
                    if (shreg[DW]) begin
                        wdata_nxt = shreg[DW-1:0];
                        wen_nxt   = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        ren_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = READ;
                    end
                end else if (scan_en) begin
                    shreg_nxt = {shreg[DW-1:0], scan_in};
                end
            end
            WRITE: begin
                wen_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            READ: begin
                // Ready on the last allowed cycle still wins over the timeout.
                if (ctr_ready) begin
                    shreg_nxt = {1'b1, ctr_rdata};
                    ren_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    shreg_nxt = '0;
                    err_nxt   = 1'b1;
                    ren_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                wen_nxt   = 1'b0;
                ren_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign scan_out = shreg[DW];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ctr_scan_host.sv
// Directed bench for ctr_scan_host with a behavioural control-register responder.
module tb_ctr_scan_host;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_en = 1'b0;
    logic          scan_in = 1'b0;
    logic          scan_update = 1'b0;
    logic          scan_out;
    logic          ctr_wen;
    logic          ctr_ren;
    logic [DW-1:0] ctr_wdata;
    logic [DW-1:0] ctr_rdata = '0;
    logic          ctr_ready = 1'b0;
    logic          busy;
    logic          err;

    logic [DW-1:0] reg_q = '0;
    int            resp_cnt = 0;
    int            resp_lat = 0;
    logic          no_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    ctr_scan_host #(.DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_in(scan_in),
        .scan_update(scan_update), .scan_out(scan_out), .ctr_wen(ctr_wen),
        .ctr_ren(ctr_ren), .ctr_wdata(ctr_wdata), .ctr_rdata(ctr_rdata),
        .ctr_ready(ctr_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Registered responder: ready asserts resp_lat+1 cycles after the request.
    always @(posedge clk) begin
        if (ctr_wen) reg_q <= ctr_wdata;
        ctr_rdata <= reg_q;
        ctr_ready <= ctr_ren && !no_resp && (resp_cnt >= resp_lat);
        resp_cnt  <= ctr_ren ? resp_cnt + 1 : 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_frame(input logic [DW:0] f);
        for (int i = DW; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = f[i];
            tick();
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic read_frame(output logic [DW:0] r);
        for (int i = DW; i >= 0; i--) begin
            r[i]    = scan_out;
            scan_en = 1'b1;
            scan_in = 1'b0;
            tick();
        end
        scan_en = 1'b0;
    endtask

    task automatic launch();
        scan_update = 1'b1;
        tick();
        scan_update = 1'b0;
    endtask

    task automatic count_ren(output int n);
        n = 0;
        while (ctr_ren === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [DW:0] fr;
        int          n;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scan_out", scan_out, 0);
        chk("rst_wen", ctr_wen, 0);
        chk("rst_ren", ctr_ren, 0);
        chk("rst_wdata", ctr_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // reset asserted mid-shift
        shift_frame(17'h1_FFFF);
        chk("shift_msb", scan_out, 1);
        scan_en = 1'b1;
        scan_in = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("midshift_rst_scan_out", scan_out, 0);
        chk("midshift_rst_busy", busy, 0);
        tick();
        rst_n   = 1'b1;
        scan_en = 1'b0;
        scan_in = 1'b0;
        tick();
        chk("post_rst_scan_out", scan_out, 0);

        // write
        shift_frame(17'h1_A5C3);
        launch();
        chk("wr_wen", ctr_wen, 1);
        chk("wr_wdata", ctr_wdata, 16'hA5C3);
        chk("wr_busy", busy, 1);
        chk("wr_ren", ctr_ren, 0);
        tick();
        chk("wr_wen_fall", ctr_wen, 0);
        chk("wr_busy_fall", busy, 0);
        chk("wr_echo", scan_out, 1);
        chk("wr_reg", reg_q, 16'hA5C3);

        // read-back
        shift_frame(17'h0_0000);
        launch();
        count_ren(n);
        chk("rd_ren_cycles", n, 2);
        chk("rd_busy", busy, 0);
        chk("rd_err", err, 0);
        read_frame(fr);
        chk("rd_frame", fr, 17'h1_A5C3);

        // timeout
        no_resp = 1'b1;
        shift_frame(17'h0_0000);
        launch();
        count_ren(n);
        chk("to_ren_cycles", n, 8);
        chk("to_err", err, 1);
        read_frame(fr);
        chk("to_frame", fr, 17'h0_0000);
        chk("to_err_sticky", err, 1);
        no_resp = 1'b0;

        // good read clears err
        shift_frame(17'h0_0000);
        launch();
        chk("clr_err_at_launch", err, 0);
        count_ren(n);
        chk("clr_ren_cycles", n, 2);
        read_frame(fr);
        chk("clr_frame", fr, 17'h1_A5C3);

        // ready on the final cycle before timeout
        no_resp = 1'b1;
        shift_frame(17'h0_0000);
        launch();
        count_ren(n);
        chk("to2_err", err, 1);
        no_resp  = 1'b0;
        resp_lat = 6;
        shift_frame(17'h0_0000);
        launch();
        count_ren(n);
        chk("last_ren_cycles", n, 8);
        chk("last_err", err, 0);
        read_frame(fr);
        chk("last_frame", fr, 17'h1_A5C3);

        // busy lockout
        shift_frame(17'h1_0F96);
        launch();
        tick();
        chk("wr2_reg", reg_q, 16'h0F96);
        resp_lat = 3;
        shift_frame(17'h0_0000);
        launch();
        n = 0;
        while (ctr_ren === 1'b1 && n < 40) begin
            n++;
            scan_en     = n[0];
            scan_in     = 1'b1;
            scan_update = (n == 2);
            tick();
        end
        scan_en     = 1'b0;
        scan_in     = 1'b0;
        scan_update = 1'b0;
        chk("lock_ren_cycles", n, 5);
        tick();
        tick();
        chk("lock_no_second_ren", ctr_ren, 0);
        chk("lock_no_wen", ctr_wen, 0);
        read_frame(fr);
        chk("lock_frame", fr, 17'h1_0F96);

        // update and shift in the same idle cycle
        resp_lat = 0;
        shift_frame(17'h1_1234);
        scan_en     = 1'b1;
        scan_in     = 1'b1;
        scan_update = 1'b1;
        tick();
        scan_en     = 1'b0;
        scan_in     = 1'b0;
        scan_update = 1'b0;
        chk("prio_wen", ctr_wen, 1);
        chk("prio_wdata", ctr_wdata, 16'h1234);
        tick();
        read_frame(fr);
        chk("prio_frame", fr, 17'h1_1234);

        // reset asserted mid-read
        resp_lat = 5;
        shift_frame(17'h0_0000);
        launch();
        tick();
        chk("mr_ren_before", ctr_ren, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_ren_async", ctr_ren, 0);
        chk("mr_busy", busy, 0);
        chk("mr_scan_out", scan_out, 0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("mr_no_capture", scan_out, 0);
        chk("mr_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
